// File: rtl/user_obi_mgr_mux_pkg.sv
// Shared types and defaults for the user-domain OBI manager multiplexer.
// Optional build macro used by the mux: USER_OBI_MUX_STATS_EN (per-port grant counters).
package user_obi_mgr_mux_pkg;

  localparam int unsigned UserMgrMuxPorts = 2;
  localparam int unsigned UserMgrMaxTrans = 2;

  // Width needed to hold an index in [0, n-1], never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  typedef logic [idx_width(UserMgrMuxPorts)-1:0] user_mgr_idx_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/user_obi_mgr_mux_if.sv
// Bus bundle around the manager mux: the upstream manager ports on one side
// and the single merged manager port toward the crossbar on the other.
// The slave modport is the mux's view; master is the surrounding system's view.
interface user_obi_mgr_mux_if
  import user_obi_mgr_mux_pkg::*;
#(
  parameter int unsigned NumSbrPorts = UserMgrMuxPorts
);

  mgr_obi_req_t [NumSbrPorts-1:0] sbr_ports_req_i;
  mgr_obi_rsp_t [NumSbrPorts-1:0] sbr_ports_rsp_o;
  mgr_obi_req_t                   mgr_port_req_o;
  mgr_obi_rsp_t                   mgr_port_rsp_i;

  modport slave (
    input  sbr_ports_req_i,
    output sbr_ports_rsp_o,
    output mgr_port_req_o,
    input  mgr_port_rsp_i
  );

  modport master (
    output sbr_ports_req_i,
    input  sbr_ports_rsp_o,
    input  mgr_port_req_o,
    output mgr_port_rsp_i
  );

endinterface

// File: rtl/user_obi_id_fifo.sv
// In-order FIFO of upstream port indices, one entry per outstanding
// transaction. Push while full and pop while empty are ignored.
module user_obi_id_fifo
  import user_obi_mgr_mux_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/user_obi_mgr_mux.sv
// N-to-1 OBI manager multiplexer: round-robin arbitration of the upstream
// managers onto one manager port, with in-order response steering via an
// index FIFO. The A channel is held on the same port from an ungranted
// request until its grant.
// Build macro USER_OBI_MUX_STATS_EN adds grant_cnt_o (one wrapping 32-bit
// handshake counter per upstream port).
module user_obi_mgr_mux
  import user_obi_mgr_mux_pkg::*;
#(
  parameter int unsigned NumSbrPorts = UserMgrMuxPorts,
  parameter int unsigned NumMaxTrans = UserMgrMaxTrans
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  user_obi_mgr_mux_if.slave              bus_if,
  output logic                           unexpected_rsp_o
`ifdef USER_OBI_MUX_STATS_EN
  ,
  output logic [NumSbrPorts-1:0][31:0]   grant_cnt_o
`endif
);

  localparam int unsigned IdxW = idx_width(NumSbrPorts);
  typedef logic [IdxW-1:0] idx_t;

  mgr_obi_req_t [NumSbrPorts-1:0] sbr_req;
  mgr_obi_rsp_t [NumSbrPorts-1:0] sbr_rsp;
  mgr_obi_rsp_t                   mgr_rsp;
  mgr_obi_req_t                   mgr_req;

  idx_t rr_q, rr_d;
  idx_t lock_idx_q;
  logic lock_q;
  idx_t win;
  logic req_out, hs, pop;
  logic fifo_full, fifo_empty;
  idx_t fifo_head;

  assign sbr_req = bus_if.sbr_ports_req_i;
  assign mgr_rsp = bus_if.mgr_port_rsp_i;

  // Winner selection: first requester at or after the pointer, unless a
  // pending ungranted request has locked the selection.
  always_comb begin
    logic found;
    int   c;
    idx_t cand;
    win   = rr_q;
    found = 1'b0;
    c     = 0;
    cand  = '0;
    for (int k = 0; k < int'(NumSbrPorts); k++) begin
      c = int'(rr_q) + k;
      if (c >= int'(NumSbrPorts)) c = c - int'(NumSbrPorts);
      cand = idx_t'(c);
      if (!found && sbr_req[cand].req) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (lock_q) win = lock_idx_q;
  end

  // A full FIFO blocks requests outright, even when a pop frees a slot this
  // cycle, so the grant never depends combinationally on rvalid.
  assign req_out = sbr_req[win].req && !fifo_full && !rst_i;
  assign hs      = req_out && mgr_rsp.gnt;
  assign pop     = mgr_rsp.rvalid && !fifo_empty && !rst_i;
  assign rr_d    = (win == idx_t'(NumSbrPorts - 1)) ? '0 : idx_t'(win + idx_t'(1));

  assign unexpected_rsp_o = mgr_rsp.rvalid && fifo_empty && !rst_i;

  // Merged A channel toward the crossbar.
  always_comb begin
    mgr_req     = '0;
    mgr_req.a   = sbr_req[win].a;
    mgr_req.req = req_out;
  end
  assign bus_if.mgr_port_req_o = mgr_req;

  // Grant to the winner only; response data broadcast, rvalid to the FIFO head.
  always_comb begin
    sbr_rsp = '0;
    for (int i = 0; i < int'(NumSbrPorts); i++) begin
      sbr_rsp[i].gnt    = hs && (win == idx_t'(i));
      sbr_rsp[i].rvalid = pop && (fifo_head == idx_t'(i));
      sbr_rsp[i].r      = mgr_rsp.r;
    end
  end
  assign bus_if.sbr_ports_rsp_o = sbr_rsp;

  // Round-robin pointer and A-channel lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      rr_q   <= rr_d;
      lock_q <= 1'b0;
    end else if (req_out) begin
      lock_q     <= 1'b1;
      lock_idx_q <= win;
    end
  end

  user_obi_id_fifo #(
    .Depth (NumMaxTrans),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (win),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef USER_OBI_MUX_STATS_EN
  logic [NumSbrPorts-1:0][31:0] grant_cnt_q;

  // Per-port handshake counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumSbrPorts); i++) begin
        if (sbr_rsp[i].gnt) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_user_obi_mgr_mux.sv
// Bench for user_obi_mgr_mux with two upstream ports and two outstanding slots.
// Each cycle states the expected request/grant; granted port indices go into a
// scoreboard queue and are popped when the bench returns a response.
module tb_user_obi_mgr_mux;
  import user_obi_mgr_mux_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic unexpected_rsp_o;
`ifdef USER_OBI_MUX_STATS_EN
  logic [1:0][31:0] grant_cnt_o;
  int unsigned      exp_cnt [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned sb_port [$];

  user_obi_mgr_mux_if #(.NumSbrPorts(2)) bus ();

  user_obi_mgr_mux #(
    .NumSbrPorts (2),
    .NumMaxTrans (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .bus_if           (bus),
    .unexpected_rsp_o (unexpected_rsp_o)
`ifdef USER_OBI_MUX_STATS_EN
    ,
    .grant_cnt_o      (grant_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] rq, input logic g, input logic rv, input logic [31:0] rd);
    bus.sbr_ports_req_i[0].req = rq[0];
    bus.sbr_ports_req_i[1].req = rq[1];
    bus.mgr_port_rsp_i.gnt     = g;
    bus.mgr_port_rsp_i.rvalid  = rv;
    bus.mgr_port_rsp_i.r.rdata = rd;
    bus.mgr_port_rsp_i.r.err   = 1'b0;
  endtask

  // One bus cycle: drive, then check grant/response against the expectations.
  task automatic cyc(input logic [1:0] rq, input logic g, input logic rv, input logic [31:0] rd,
                     input logic exp_req, input logic [1:0] exp_gnt);
    logic [1:0] gnt_obs, rv_obs, rv_exp;
    logic       exp_unexp;
    @(negedge clk_i);
    drive(rq, g, rv, rd);
    #1;
    gnt_obs   = {bus.sbr_ports_rsp_o[1].gnt, bus.sbr_ports_rsp_o[0].gnt};
    rv_obs    = {bus.sbr_ports_rsp_o[1].rvalid, bus.sbr_ports_rsp_o[0].rvalid};
    rv_exp    = 2'b00;
    exp_unexp = 1'b0;
    check_val("req_o", bus.mgr_port_req_o.req, exp_req);
    check_val("gnt", gnt_obs, exp_gnt);
    if (rv) begin
      if (sb_port.size() > 0) begin
        int unsigned hp;
        hp = sb_port.pop_front();
        rv_exp[hp] = 1'b1;
        check_val("rdata", bus.sbr_ports_rsp_o[hp].r.rdata, rd);
      end else begin
        exp_unexp = 1'b1;
      end
    end
    check_val("rvalid", rv_obs, rv_exp);
    check_val("unexpected", unexpected_rsp_o, exp_unexp);
    for (int p = 0; p < 2; p++) begin
      if (exp_gnt[p]) begin
        sb_port.push_back(p);
`ifdef USER_OBI_MUX_STATS_EN
        exp_cnt[p]++;
`endif
      end
    end
  endtask

  // Assert reset with busy inputs, check outputs are quiet, then release.
  task automatic apply_reset();
    logic [1:0] gnt_obs, rv_obs;
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h1234_5678);
    #1;
    gnt_obs = {bus.sbr_ports_rsp_o[1].gnt, bus.sbr_ports_rsp_o[0].gnt};
    rv_obs  = {bus.sbr_ports_rsp_o[1].rvalid, bus.sbr_ports_rsp_o[0].rvalid};
    check_val("rst_req_o", bus.mgr_port_req_o.req, 1'b0);
    check_val("rst_gnt", gnt_obs, 2'b00);
    check_val("rst_rvalid", rv_obs, 2'b00);
    check_val("rst_unexpected", unexpected_rsp_o, 1'b0);
    sb_port.delete();
`ifdef USER_OBI_MUX_STATS_EN
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    check_val("rst_cnt0", grant_cnt_o[0], 64'd0);
    check_val("rst_cnt1", grant_cnt_o[1], 64'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.sbr_ports_req_i          = '0;
    bus.mgr_port_rsp_i           = '0;
    bus.sbr_ports_req_i[0].a.addr  = 32'h0000_1000;
    bus.sbr_ports_req_i[0].a.we    = 1'b0;
    bus.sbr_ports_req_i[0].a.be    = 4'hF;
    bus.sbr_ports_req_i[0].a.wdata = 32'h0;
    bus.sbr_ports_req_i[1].a.addr  = 32'h0000_2000;
    bus.sbr_ports_req_i[1].a.we    = 1'b1;
    bus.sbr_ports_req_i[1].a.be    = 4'h3;
    bus.sbr_ports_req_i[1].a.wdata = 32'hB1B1_1111;

    // Single read from port 0, response two cycles after the grant.
    apply_reset();
    cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01);
    check_val("t1_addr", bus.mgr_port_req_o.a.addr, 32'h0000_1000);
    cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b00);

    // Both ports requesting with gnt high: alternating grants, in-order responses.
    apply_reset();
    cyc(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01);
    cyc(2'b11, 1'b1, 1'b1, 32'hD000_0001, 1'b1, 2'b10);
    cyc(2'b11, 1'b1, 1'b1, 32'hD000_0002, 1'b1, 2'b01);
    cyc(2'b11, 1'b1, 1'b1, 32'hD000_0003, 1'b1, 2'b10);
    cyc(2'b01, 1'b1, 1'b1, 32'hD000_0004, 1'b1, 2'b01);
    cyc(2'b00, 1'b0, 1'b1, 32'hD000_0005, 1'b0, 2'b00);
`ifdef USER_OBI_MUX_STATS_EN
    check_val("cnt0_after5", grant_cnt_o[0], 64'(exp_cnt[0]));
    check_val("cnt1_after5", grant_cnt_o[1], 64'(exp_cnt[1]));
`endif

    // Port 1 held ungranted while port 0 joins: selection stays on port 1.
    apply_reset();
    cyc(2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
    check_val("lock_addr_c0", bus.mgr_port_req_o.a.addr, 32'h0000_2000);
    cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
    check_val("lock_addr_c1", bus.mgr_port_req_o.a.addr, 32'h0000_2000);
    cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
    check_val("lock_wdata_c2", bus.mgr_port_req_o.a.wdata, 32'hB1B1_1111);
    cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10);
    cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01);
    check_val("after_lock_addr", bus.mgr_port_req_o.a.addr, 32'h0000_1000);
    cyc(2'b00, 1'b0, 1'b1, 32'hE000_0001, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, 1'b1, 32'hE000_0002, 1'b0, 2'b00);

    // Outstanding limit: two grants fill the FIFO, pop-cycle still blocked.
    apply_reset();
    cyc(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01);
    cyc(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10);
    cyc(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00);
    cyc(2'b11, 1'b1, 1'b1, 32'hF000_0001, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01);
    cyc(2'b00, 1'b0, 1'b1, 32'hF000_0002, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, 1'b1, 32'hF000_0003, 1'b0, 2'b00);

    // Response with nothing outstanding: one-cycle unexpected pulse.
    cyc(2'b00, 1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00);

    // Reset with two transactions outstanding; the late response is unexpected.
    apply_reset();
    cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01);
    cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10);
    apply_reset();
    cyc(2'b00, 1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/user_obi_mgr_mux.md
Name: user_obi_mgr_mux

Overview:
- N-to-1 OBI manager multiplexer for the user domain. It arbitrates several user-side OBI managers (accelerator DMA ports and similar) onto the single user manager port toward the crossbar.
- It is the counterpart of the user subordinate demux. It merges requests instead of splitting them, and it steers each returning response to the manager that issued it.
- It tracks outstanding transactions in order with an ID FIFO.

Parameters:
- NumSbrPorts, 2, number of upstream managers (at least 1).
- NumMaxTrans, 2, maximum outstanding transactions; sets the depth of the ID FIFO.
- obi_req_t, mgr_obi_req_t, OBI request struct type (fields a.addr, a.we, a.be, a.wdata, req).
- obi_rsp_t, mgr_obi_rsp_t, OBI response struct type (fields gnt, rvalid, r.rdata, r.err).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- sbr_ports_req_i  in  NumSbrPorts x obi_req_t  requests from the upstream managers.
- sbr_ports_rsp_o  out  NumSbrPorts x obi_rsp_t  responses to the upstream managers.
- mgr_port_req_o  out  obi_req_t  merged request toward the crossbar.
- mgr_port_rsp_i  in  obi_rsp_t  response from the crossbar.
- unexpected_rsp_o  out  1  one-cycle pulse when rvalid arrives while the ID FIFO is empty.

Behaviour:
- Reset state and values:
  - Round-robin pointer = 0, ID FIFO empty, lock flag clear.
  - While rst_i is high: mgr_port_req_o.req = 0, all gnt = 0, all rvalid = 0, unexpected_rsp_o = 0.
- Arbitration:
  - Round-robin arbitration starts at the pointer.
  - The winner's A channel is passed combinationally to mgr_port_req_o; req_o = winner.req AND NOT fifo_full.
  - Zero-cycle latency from request to output.
- Lock:
  - If req_o is high and gnt_i is low, register the winner index and set the lock flag.
  - While locked, the selection must not change, even if higher-priority ports raise req (OBI A-channel stability).
  - The lock clears on the gnt handshake.
- Grant:
  - sbr_ports_rsp_o[w].gnt = mgr_port_rsp_i.gnt AND req_o; gnt to every other port is 0.
  - On a handshake, push the winner index into the ID FIFO and set pointer = (w+1) mod NumSbrPorts.
- Response:
  - On rvalid_i with the FIFO non-empty, route rvalid, rdata and err to the port at the FIFO head, then pop.
  - rdata and err are broadcast to all ports; rvalid goes only to the head port.
  - Zero-cycle latency.
- FIFO full:
  - req_o is forced low, so no grants are issued.
  - This holds even if a pop occurs in the same cycle (no push-on-pop-when-full). This keeps gnt off the rvalid path.
- FIFO empty plus rvalid_i: no port receives rvalid, the response is dropped, and unexpected_rsp_o pulses for 1 cycle.
- Simultaneous push and pop when the FIFO is not full: both happen and the count is unchanged.
- Reset mid-transaction: outstanding IDs are discarded. Late responses after reset trigger the unexpected pulse and are dropped.
- NumSbrPorts = 1: the arbiter degenerates to a pass-through and the FIFO still tracks outstanding count.

Optional Feature:
- Macro: USER_OBI_MUX_STATS_EN.
- Defined:
  - Adds output grant_cnt_o, NumSbrPorts x 32, with one counter per port.
  - A counter increments on each gnt handshake for that port and wraps at 2^32-1 -> 0.
  - Counters reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- user_pkg gains:
  - UserMgrMuxPorts (value of NumSbrPorts at instantiation).
  - UserMgrMaxTrans.
  - Typedef user_mgr_idx_t = logic[$clog2(NumSbrPorts)-1:0] (minimum width 1).
- One natural sub-module, user_obi_id_fifo: a parameterised-depth FIFO of indices with push, pop, full, empty and head, and an active-high async reset.

Test Plan:
- Single port 0 read at addr 0x1000: gnt in the same cycle; rvalid two cycles later with rdata 0xCAFEF00D reaches port 0 only; port 1 sees no rvalid.
- Ports 0 and 1 request continuously with gnt always high: grants alternate 0,1,0,1 over 4 cycles; responses are returned in order to 0,1,0,1.
- Port 1 requests with gnt held low for 3 cycles while port 0 raises req in cycle 1: the output stays on port 1's addr and wdata until gnt, then serves port 0.
- NumMaxTrans = 2 with rvalid withheld: after 2 grants req_o drops despite pending requests; one rvalid frees a slot, and the next cycle grants again.
- rvalid with no outstanding transaction: unexpected_rsp_o = 1 for exactly 1 cycle and no port rvalid.
- Assert rst_i with 2 transactions outstanding: outputs go to 0 immediately; late rvalid pulses unexpected_rsp_o. With USER_OBI_MUX_STATS_EN, grant_cnt_o reads {0,0} after reset and {3,2} after 5 alternating grants.
